ram_sp_param: RTL and testbench
===============================

Name: ram_sp_param

Overview:
- Parametrised single-port synchronous RAM with a shared bidirectional data bus and cs/rd/wr control; the next generation of the team's 1K x 8 memory model.
- Adds configurable width and depth, configurable read latency, and a read-valid strobe.
- Adds clear-on-reset through an internal init sequencer with a busy flag, and a sticky error flag for illegal accesses.
- Used as the generic scratch/buffer memory behind bus-attached peripherals.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 10, address width; DEPTH = 2**ADDR_W words.
- RD_LAT, 1, read latency in clock edges; legal values 1 or 2.
- CLEAR_ON_RESET, 1, when 1 the init sequencer writes INIT_VAL to every word after reset.
- INIT_VAL, 0, DATA_W-bit value written by the init sequencer.

Ports:
- clk  input  1  system clock; all sequential logic on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- cs  input  1  chip select.
- rd  input  1  read request, sampled with cs.
- wr  input  1  write request, sampled with cs.
- addr  input  ADDR_W  word address.
- data  inout  DATA_W  write data in; read data out (tri-state).
- rd_valid  output  1  read data present on data this cycle.
- busy  output  1  init sequence in progress; accesses are not accepted.
- err  output  1  sticky illegal-access flag.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset asserted (immediate, no clock needed):
  - busy=1, rd_valid=0, err=0.
  - data released to Z.
  - Read pipeline flushed; init counter=0.
  - Memory contents are not cleared asynchronously.
- FSM states INIT, READY.
  - Reset forces INIT.
  - CLEAR_ON_RESET=1: INIT writes INIT_VAL to address cnt on each edge, cnt 0..DEPTH-1, DEPTH edges total. On the edge writing DEPTH-1, go to READY; busy=0 from that edge.
  - CLEAR_ON_RESET=0: INIT lasts one edge, then READY.
  - Reset asserted during INIT restarts clearing at address 0.
- Access decode at a rising edge, READY only:
  - Write: cs=1, wr=1, rd=0 → mem[addr] <= data. The value is readable by a read sampled on the next edge.
  - Read: cs=1, rd=1, wr=0 → mem[addr] is captured at this edge (edge N).
    - RD_LAT=1: data driven and rd_valid=1 for the cycle after edge N.
    - RD_LAT=2: an extra output register; valid for the cycle after edge N+1.
  - Reads are fully pipelined: one read accepted per cycle; back-to-back reads give back-to-back rd_valid.
  - Conflict: cs=1, rd=1, wr=1 → no memory access, no rd_valid, err set.
  - cs=0, or rd=wr=0 → no operation.
- Access during INIT: cs=1 with rd or wr is ignored (no write, no rd_valid) and sets err.
- err: once set, stays 1 until rst_n asserted.
- Bus drive:
  - data is driven only while rd_valid=1; Z otherwise, including cs=0.
  - The external master must not drive data while rd_valid=1.
- Read/write ordering:
  - A write on edge N+1 to an address read at edge N does not affect that read (old data returned).
  - A read following a write to the same address returns the new data.
- Address wrap: none; DEPTH covers the full address space, so every addr is valid.
- RD_LAT outside {1,2}: elaboration error.

Test Plan:
- Reset/init, DATA_W=8, ADDR_W=4, INIT_VAL=8'hA5: release rst_n → busy=1 for exactly 16 edges, then 0. Reading addresses 0..15 returns 8'hA5 each, rd_valid=1 one cycle after each request.
- Write/read, RD_LAT=1: write 8'h3C to 10'h2F, then read 10'h2F on the next edge → data=8'h3C with rd_valid=1 one cycle after the read edge. data=Z in the cycle before and after.
- Pipelined reads, RD_LAT=2: after writing addr 1..4 with 8'h11, 8'h22, 8'h33, 8'h44, issue reads on 4 consecutive edges → rd_valid high for 4 consecutive cycles starting 2 cycles after the first read, data 11,22,33,44 in order.
- Conflict: cs=rd=wr=1 with addr 5, data 8'hFF (addr 5 holds 8'h00) → err=1 and stays 1, no rd_valid, a later read of addr 5 returns 8'h00. err returns to 0 only on rst_n=0.
- Access during INIT: write 8'h77 to addr 3 while busy=1 → err=1; after init, addr 3 reads INIT_VAL.
- Reset mid-operation: assert rst_n while a read is in flight and halfway through a re-init → rd_valid=0 and data=Z immediately (asynchronous). After release, busy lasts a full DEPTH edges.

Source files
------------

// File: rtl/ram_sp_param.sv
// rtl/ram_sp_param.sv - parametrised single-port synchronous RAM with init sequencer
module ram_sp_param #(
   parameter int unsigned       DATA_W         = 8,
   parameter int unsigned       ADDR_W         = 10,
   parameter int unsigned       RD_LAT         = 1,
   parameter bit                CLEAR_ON_RESET = 1'b1,
   parameter logic [DATA_W-1:0] INIT_VAL       = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cs,
   input  logic              rd,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   inout  wire  [DATA_W-1:0] data,
   output logic              rd_valid,
   output logic              busy,
   output logic              err
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
      $error("ram_sp_param: RD_LAT must be 1 or 2");
   end

   typedef enum logic {ST_INIT, ST_READY} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic              v1_q, v1_d;
   logic              v2_q, v2_d;
   logic [DATA_W-1:0] rdata1_q;
   logic [DATA_W-1:0] rdata2_q, rdata2_d;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              access;
   logic              rd_fire;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      err_d     = err_q;
      mem_we    = 1'b0;
      mem_waddr = addr;
      mem_wdata = data;
      rd_fire   = 1'b0;
      access    = cs && (rd || wr);

      if (state_q == ST_INIT) begin
         // The sequencer owns the array while busy; any master access is refused and flagged.
         if (access) begin
            err_d = 1'b1;
         end
         if (CLEAR_ON_RESET) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = INIT_VAL;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == {ADDR_W{1'b1}}) begin
               state_d = ST_READY;
               busy_d  = 1'b0;
            end
         end else begin
            state_d = ST_READY;
            busy_d  = 1'b0;
         end
      end else if (cs) begin
         if (rd && wr) begin
            err_d = 1'b1;
         end else if (wr) begin
            mem_we = 1'b1;
         end else if (rd) begin
            rd_fire = 1'b1;
         end
      end

      v1_d     = rd_fire;
      v2_d     = v1_q;
      rdata2_d = rdata1_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_INIT;
         cnt_q    <= '0;
         busy_q   <= 1'b1;
         err_q    <= 1'b0;
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         rdata2_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
         v1_q     <= v1_d;
         v2_q     <= v2_d;
         rdata2_q <= rdata2_d;
      end
   end

   // Array and first read register stay out of reset so the storage maps onto a plain RAM macro.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
      if (rd_fire) begin
         rdata1_q <= mem[addr];
      end
   end

   assign rd_valid = (RD_LAT == 2) ? v2_q : v1_q;
   assign busy     = busy_q;
   assign err      = err_q;
   assign data     = rd_valid ? ((RD_LAT == 2) ? rdata2_q : rdata1_q) : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_sp_param.sv
// tb/tb_ram_sp_param.sv - randomized self-checking bench for ram_sp_param
module tb_ram_sp_param;
   localparam int N = 3;
   localparam int         LAT [N] = '{1, 2, 1};
   localparam int         AW  [N] = '{4, 10, 10};
   localparam bit         CLR [N] = '{1'b1, 1'b1, 1'b0};
   localparam logic [7:0] IV  [N] = '{8'hA5, 8'h00, 8'h00};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic [N-1:0] cs;
   logic         rd, wr;
   logic [9:0]   addr;
   logic [7:0]   wdata;
   wire  [7:0]   bus0, bus1, bus2;
   wire  [N-1:0] rv, bsy, er;

   assign bus0 = (cs[0] && wr) ? wdata : 8'bz;
   assign bus1 = (cs[1] && wr) ? wdata : 8'bz;
   assign bus2 = (cs[2] && wr) ? wdata : 8'bz;

   ram_sp_param #(.DATA_W(8), .ADDR_W(4), .RD_LAT(1), .CLEAR_ON_RESET(1'b1), .INIT_VAL(8'hA5)) u_s (
      .clk(clk), .rst_n(rst_n), .cs(cs[0]), .rd(rd), .wr(wr), .addr(addr[3:0]),
      .data(bus0), .rd_valid(rv[0]), .busy(bsy[0]), .err(er[0]));
   ram_sp_param #(.DATA_W(8), .ADDR_W(10), .RD_LAT(2), .CLEAR_ON_RESET(1'b1), .INIT_VAL(8'h00)) u_l (
      .clk(clk), .rst_n(rst_n), .cs(cs[1]), .rd(rd), .wr(wr), .addr(addr),
      .data(bus1), .rd_valid(rv[1]), .busy(bsy[1]), .err(er[1]));
   ram_sp_param #(.DATA_W(8), .ADDR_W(10), .RD_LAT(1), .CLEAR_ON_RESET(1'b0), .INIT_VAL(8'h00)) u_m (
      .clk(clk), .rst_n(rst_n), .cs(cs[2]), .rd(rd), .wr(wr), .addr(addr),
      .data(bus2), .rd_valid(rv[2]), .busy(bsy[2]), .err(er[2]));

   typedef struct {
      int         due;
      logic [7:0] dat;
   } rd_t;

   rd_t        rq [N][$];
   logic [7:0] mmem [N][1024];
   int         busy_left [N];
   bit         merr [N];
   bit         last_v [N];
   int         fall_e [N];
   int         ecnt, rel_e, n_chk, n_pass;
   logic [7:0] zz = 8'bz;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [7:0] bus_of(input int i);
      case (i)
         0:       return bus0;
         1:       return bus1;
         default: return bus2;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         busy_left[i] = CLR[i] ? (1 << AW[i]) : 1;
         merr[i]      = 1'b0;
         last_v[i]    = 1'b0;
         fall_e[i]    = -1;
         rq[i].delete();
      end
   endtask

   task automatic model_edge();
      ecnt++;
      if (!rst_n) return;
      for (int i = 0; i < N; i++) begin
         int a = int'(addr) & ((1 << AW[i]) - 1);
         if (busy_left[i] > 0) begin
            if (cs[i] && (rd || wr)) merr[i] = 1'b1;
            if (CLR[i]) mmem[i][(1 << AW[i]) - busy_left[i]] = IV[i];
            busy_left[i]--;
         end else if (cs[i]) begin
            if (rd && wr) merr[i] = 1'b1;
            else if (wr) mmem[i][a] = wdata;
            else if (rd) rq[i].push_back('{due: ecnt + LAT[i] - 1, dat: mmem[i][a]});
         end
      end
   endtask

   task automatic check_outputs();
      for (int i = 0; i < N; i++) begin
         bit ev = (rq[i].size() > 0) && (rq[i][0].due == ecnt);
         chk($sformatf("rd_valid[%0d]", i), rv[i], ev);
         if (ev) begin
            chk($sformatf("rdata[%0d]", i), bus_of(i), rq[i][0].dat);
            void'(rq[i].pop_front());
         end else begin
            chk($sformatf("data_z[%0d]", i), bus_of(i), zz);
         end
         chk($sformatf("busy[%0d]", i), bsy[i], busy_left[i] > 0);
         chk($sformatf("err[%0d]", i), er[i], merr[i]);
         last_v[i] = ev;
         if (fall_e[i] < 0 && rst_n && !bsy[i]) fall_e[i] = ecnt;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      cs = '0;
      rd = 1'b0;
      wr = 1'b0;
      #1;
      check_outputs();
   endtask

   task automatic op(input logic [N-1:0] m, input bit r, input bit w, input int a, input logic [7:0] d);
      cs    = m;
      rd    = r;
      wr    = w;
      addr  = 10'(a);
      wdata = d;
      cycle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; cs = '0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
      ecnt = 0; n_chk = 0; n_pass = 0;
      model_reset();
      repeat (3) cycle();
      rst_n = 1'b1;
      rel_e = ecnt;

      // access while the sequencer is clearing must be refused
      op(3'b001, 1'b0, 1'b1, 3, 8'h77);
      chk("err_init_write", er[0], 1'b1);
      for (int k = 0; k < 40 && bsy[0]; k++) cycle();
      chk("busy_edges_s", fall_e[0] - rel_e, 16);
      for (int a = 0; a < 16; a++) op(3'b001, 1'b1, 1'b0, a, 8'h00);
      repeat (2) cycle();

      for (int a = 0; a < 1024; a++) op(3'b100, 1'b0, 1'b1, a, 8'($urandom));
      for (int k = 0; k < 1100 && bsy[1]; k++) cycle();
      chk("busy_edges_l", fall_e[1] - rel_e, 1024);
      chk("busy_edges_m", fall_e[2] - rel_e, 1);

      op(3'b100, 1'b0, 1'b1, 10'h2F, 8'h3C);
      op(3'b100, 1'b1, 1'b0, 10'h2F, 8'h00);
      chk("wr_rd_2f", bus2, 8'h3C);
      cycle();

      for (int a = 1; a <= 4; a++) op(3'b010, 1'b0, 1'b1, a, 8'(8'h11 * a));
      for (int a = 1; a <= 4; a++) op(3'b010, 1'b1, 1'b0, a, 8'h00);
      repeat (3) cycle();

      op(3'b010, 1'b1, 1'b1, 5, 8'hFF);
      chk("err_conflict", er[1], 1'b1);
      op(3'b010, 1'b1, 1'b0, 5, 8'h00);
      repeat (2) cycle();
      chk("err_sticky", er[1], 1'b1);

      for (int k = 0; k < 800; k++) begin
         int           sel = $urandom_range(0, 19);
         bit           r   = (sel < 9) || (sel == 19);
         bit           w   = (sel >= 9);
         logic [N-1:0] m   = 3'($urandom_range(0, 7));
         if (sel >= 15 && sel < 19) m = '0;
         // never drive the bus into a memory that is presenting read data this cycle
         if (w) for (int i = 0; i < N; i++) if (last_v[i]) m[i] = 1'b0;
         op(m, r, w, int'($urandom_range(0, 1023)), 8'($urandom));
      end

      rst_n = 1'b0;
      model_reset();
      repeat (2) cycle();
      rst_n = 1'b1;
      rel_e = ecnt;
      repeat (512) cycle();
      op(3'b101, 1'b1, 1'b0, 7, 8'h00);
      chk("read_in_flight", rv[0], 1'b1);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs();
      repeat (2) cycle();
      rst_n = 1'b1;
      rel_e = ecnt;
      for (int k = 0; k < 1100 && bsy[1]; k++) cycle();
      chk("busy_edges_s2", fall_e[0] - rel_e, 16);
      chk("busy_edges_l2", fall_e[1] - rel_e, 1024);
      for (int k = 0; k < 8; k++) op(3'b111, 1'b1, 1'b0, int'($urandom_range(0, 1023)), 8'h00);
      repeat (3) cycle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
